// File: rtl/color_pipe_selector_if.sv
// Pixel request / colour result bundle for color_pipe_selector.
// The master drives requests and downstream ready; the slave returns the selection.
interface color_pipe_selector_if #(
    parameter int RECT_COUNT  = 64,
    parameter int COLOR_WIDTH = 16
);
    localparam int IDX_W = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [RECT_COUNT-1:0]  collisions;
    logic [COLOR_WIDTH-1:0] rect_colors [RECT_COUNT];
    logic                   frame_start;
    logic                   out_valid;
    logic                   out_ready;
    logic [COLOR_WIDTH-1:0] color;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [15:0]            miss_count;

    modport master (
        output in_valid, collisions, rect_colors, frame_start, out_ready,
        input  in_ready, out_valid, color, hit, hit_idx, miss_count
    );

    modport slave (
        input  in_valid, collisions, rect_colors, frame_start, out_ready,
        output in_ready, out_valid, color, hit, hit_idx, miss_count
    );
endinterface

// File: rtl/color_pipe_selector.sv
// Two-stage priority selector: picks the lowest-index non-transparent rectangle
// covering a pixel, resolving per group first and across groups second.
module color_pipe_selector #(
    parameter int                     RECT_COUNT    = 64,
    parameter int                     COLOR_WIDTH   = 16,
    parameter int                     GROUP_SIZE    = 8,
    parameter logic [COLOR_WIDTH-1:0] DEFAULT_COLOR = 16'h0000,
    parameter bit                     TRANSP_EN     = 1'b1,
    parameter logic [COLOR_WIDTH-1:0] TRANSP_COLOR  = 16'hF81F
) (
    input logic                  clk,
    input logic                  rst_n,
    color_pipe_selector_if.slave bus
);
    localparam int NUM_GRP = RECT_COUNT / GROUP_SIZE;
    localparam int OFF_W   = $clog2(GROUP_SIZE);
    localparam int IDX_W   = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;

    if (RECT_COUNT % GROUP_SIZE != 0) begin : g_bad_count
        $error("RECT_COUNT must be a multiple of GROUP_SIZE");
    end
    if (GROUP_SIZE < 2 || (GROUP_SIZE & (GROUP_SIZE - 1)) != 0) begin : g_bad_group
        $error("GROUP_SIZE must be a power of 2 and at least 2");
    end

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                   adv;
    logic                   xfer;
    logic                   miss_xfer;
    logic                   vld_p1_q;
    logic                   vld_p2_q;
    logic [RECT_COUNT-1:0]  eff;

    logic [NUM_GRP-1:0]     grp_hit_d,    grp_hit_p1_q;
    logic [OFF_W-1:0]       grp_off_d     [NUM_GRP];
    logic [OFF_W-1:0]       grp_off_p1_q  [NUM_GRP];
    logic [COLOR_WIDTH-1:0] grp_col_d     [NUM_GRP];
    logic [COLOR_WIDTH-1:0] grp_col_p1_q  [NUM_GRP];

    logic [COLOR_WIDTH-1:0] color_d,  color_p2_q;
    logic                   hit_d,    hit_p2_q;
    logic [IDX_W-1:0]       idx_d,    idx_p2_q;
    logic [15:0]            miss_d,   miss_q;

    assign adv          = !vld_p2_q || bus.out_ready;
    assign xfer         = vld_p2_q && bus.out_ready;
    assign miss_xfer    = xfer && !hit_p2_q;
    assign bus.in_ready = adv;

    always_comb begin
        for (int i = 0; i < RECT_COUNT; i++) begin
            eff[i] = bus.collisions[i] && !(TRANSP_EN && (bus.rect_colors[i] == TRANSP_COLOR));
        end
    end

    // Stage 1: lowest set bit inside each group (descending scan so the lowest wins).
    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            grp_hit_d[g] = 1'b0;
            grp_off_d[g] = '0;
            grp_col_d[g] = DEFAULT_COLOR;
            for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
                if (eff[g*GROUP_SIZE + k]) begin
                    grp_hit_d[g] = 1'b1;
                    grp_off_d[g] = OFF_W'(k);
                    grp_col_d[g] = bus.rect_colors[g*GROUP_SIZE + k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv && bus.in_valid) begin
            grp_hit_p1_q <= grp_hit_d;
            grp_off_p1_q <= grp_off_d;
            grp_col_p1_q <= grp_col_d;
        end
    end

    // Stage 2: lowest group with a hit supplies the final colour and index.
    always_comb begin
        color_d = DEFAULT_COLOR;
        hit_d   = 1'b0;
        idx_d   = '0;
        for (int g = NUM_GRP - 1; g >= 0; g--) begin
            if (grp_hit_p1_q[g]) begin
                color_d = grp_col_p1_q[g];
                hit_d   = 1'b1;
                idx_d   = IDX_W'(g * GROUP_SIZE) + IDX_W'(grp_off_p1_q[g]);
            end
        end
    end

    // A transfer coinciding with frame_start belongs to the new frame.
    always_comb begin
        miss_d = miss_q;
        if (bus.frame_start) begin
            miss_d = miss_xfer ? 16'd1 : 16'd0;
        end else if (miss_xfer) begin
            miss_d = sat_inc16(miss_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            color_p2_q <= DEFAULT_COLOR;
            hit_p2_q   <= 1'b0;
            idx_p2_q   <= '0;
            miss_q     <= 16'd0;
        end else begin
            miss_q <= miss_d;
            if (adv) begin
                vld_p1_q <= bus.in_valid;
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) begin
                    color_p2_q <= color_d;
                    hit_p2_q   <= hit_d;
                    idx_p2_q   <= idx_d;
                end
            end
        end
    end

    assign bus.out_valid  = vld_p2_q;
    assign bus.color      = color_p2_q;
    assign bus.hit        = hit_p2_q;
    assign bus.hit_idx    = idx_p2_q;
    assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_color_pipe_selector.sv
// Directed bench for color_pipe_selector: priority, transparency, backpressure,
// miss statistics, saturation and reset behaviour.
module tb_color_pipe_selector;
    localparam int RC = 64;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    color_pipe_selector_if #(.RECT_COUNT(RC), .COLOR_WIDTH(CW)) bus ();

    color_pipe_selector #(
        .RECT_COUNT(RC), .COLOR_WIDTH(CW), .GROUP_SIZE(8),
        .DEFAULT_COLOR(16'h0000), .TRANSP_EN(1'b1), .TRANSP_COLOR(16'hF81F)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic init_colors;
        for (int i = 0; i < RC; i++) bus.rect_colors[i] = 16'h0100 + 16'(i);
    endtask

    // Sends one pixel with out_ready high, captures the result, lets it transfer.
    task automatic send_one(input logic [63:0] c, output logic ov, output logic [15:0] col,
                            output logic h, output logic [5:0] idx);
        bus.in_valid   = 1'b1;
        bus.collisions = c;
        bus.out_ready  = 1'b1;
        cyc;
        bus.in_valid   = 1'b0;
        bus.collisions = '1;
        cyc;
        ov  = bus.out_valid;
        col = bus.color;
        h   = bus.hit;
        idx = bus.hit_idx;
        cyc;
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.frame_start = 1'b0;
        bus.collisions  = '0;
        init_colors;
        cyc;
        cyc;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.color !== 16'h0000) begin errors++; $display("FAIL rst_color: got %h expected 0000", bus.color); end
        checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b expected 0", bus.hit); end
        checks++; if (bus.hit_idx !== 6'd0) begin errors++; $display("FAIL rst_hit_idx: got %0d expected 0", bus.hit_idx); end
        checks++; if (bus.miss_count !== 16'd0) begin errors++; $display("FAIL rst_miss_count: got %0d expected 0", bus.miss_count); end
        rst_n = 1'b1;
        cyc;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_latency;
        bus.rect_colors[4] = 16'h1234;
        bus.rect_colors[5] = 16'h5678;
        bus.in_valid   = 1'b1;
        bus.collisions = 64'h0000_0000_0000_0030;
        bus.out_ready  = 1'b1;
        cyc;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b expected 0", bus.out_valid); end
        bus.in_valid   = 1'b0;
        bus.collisions = '1;
        cyc;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.color !== 16'h1234) begin errors++; $display("FAIL lat_color: got %h expected 1234", bus.color); end
        checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL lat_hit: got %b expected 1", bus.hit); end
        checks++; if (bus.hit_idx !== 6'd4) begin errors++; $display("FAIL lat_idx: got %0d expected 4", bus.hit_idx); end
        cyc;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_no_dup: got %b expected 0", bus.out_valid); end
        checks++; if (bus.miss_count !== 16'd0) begin errors++; $display("FAIL lat_miss_count: got %0d expected 0", bus.miss_count); end
        init_colors;
    endtask

    task automatic test_miss;
        logic ov, h;
        logic [15:0] col;
        logic [5:0] idx;
        send_one(64'd0, ov, col, h, idx);
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL miss_valid: got %b expected 1", ov); end
        checks++; if (col !== 16'h0000) begin errors++; $display("FAIL miss_color: got %h expected 0000", col); end
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b expected 0", h); end
        checks++; if (idx !== 6'd0) begin errors++; $display("FAIL miss_idx: got %0d expected 0", idx); end
        checks++; if (bus.miss_count !== 16'd1) begin errors++; $display("FAIL miss_count_inc: got %0d expected 1", bus.miss_count); end
    endtask

    task automatic test_priority_transparency;
        logic ov, h;
        logic [15:0] col;
        logic [5:0] idx;
        bus.rect_colors[9]  = 16'hF81F;
        bus.rect_colors[40] = 16'h07E0;
        send_one((64'd1 << 9) | (64'd1 << 40), ov, col, h, idx);
        checks++; if (col !== 16'h07E0 || h !== 1'b1 || idx !== 6'd40) begin errors++; $display("FAIL transp_skip: got col=%h hit=%b idx=%0d expected col=07e0 hit=1 idx=40", col, h, idx); end
        send_one(64'd1 << 9, ov, col, h, idx);
        checks++; if (col !== 16'h0000 || h !== 1'b0 || idx !== 6'd0) begin errors++; $display("FAIL transp_only: got col=%h hit=%b idx=%0d expected col=0000 hit=0 idx=0", col, h, idx); end
        checks++; if (bus.miss_count !== 16'd2) begin errors++; $display("FAIL transp_miss_count: got %0d expected 2", bus.miss_count); end
        send_one((64'd1 << 63) | (64'd1 << 20) | (64'd1 << 17), ov, col, h, idx);
        checks++; if (col !== 16'h0111 || h !== 1'b1 || idx !== 6'd17) begin errors++; $display("FAIL prio_in_group: got col=%h hit=%b idx=%0d expected col=0111 hit=1 idx=17", col, h, idx); end
        send_one(64'd1 << 63, ov, col, h, idx);
        checks++; if (col !== 16'h013F || h !== 1'b1 || idx !== 6'd63) begin errors++; $display("FAIL prio_top: got col=%h hit=%b idx=%0d expected col=013f hit=1 idx=63", col, h, idx); end
        send_one((64'd1 << 63) | 64'd1, ov, col, h, idx);
        checks++; if (col !== 16'h0100 || h !== 1'b1 || idx !== 6'd0) begin errors++; $display("FAIL prio_bit0: got col=%h hit=%b idx=%0d expected col=0100 hit=1 idx=0", col, h, idx); end
        init_colors;
    endtask

    task automatic test_back_to_back;
        bit          rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          tx = 0;
        int          rx = 0;
        int          exp_idx;
        logic        stalled = 1'b0;
        logic [15:0] s_col;
        logic        s_hit;
        logic [5:0]  s_idx;
        for (int t = 0; t < 40 && rx < 5; t++) begin
            bus.out_ready = (t < 7) ? rdy_pat[t] : 1'b1;
            if (tx < 5) begin
                bus.in_valid   = 1'b1;
                bus.collisions = 64'd1 << (tx * 13 + 1);
            end else begin
                bus.in_valid   = 1'b0;
                bus.collisions = '1;
            end
            #1;
            if (stalled) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.color !== s_col || bus.hit !== s_hit || bus.hit_idx !== s_idx) begin
                    errors++;
                    $display("FAIL b2b_hold: got v=%b col=%h hit=%b idx=%0d expected v=1 col=%h hit=%b idx=%0d",
                             bus.out_valid, bus.color, bus.hit, bus.hit_idx, s_col, s_hit, s_idx);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b expected 0", bus.in_ready); end
                stalled = 1'b1;
                s_col = bus.color;
                s_hit = bus.hit;
                s_idx = bus.hit_idx;
            end else begin
                stalled = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                exp_idx = rx * 13 + 1;
                checks++;
                if (bus.color !== 16'h0100 + 16'(exp_idx) || bus.hit !== 1'b1 || bus.hit_idx !== 6'(exp_idx)) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got col=%h hit=%b idx=%0d expected col=%h hit=1 idx=%0d",
                             rx, bus.color, bus.hit, bus.hit_idx, 16'h0100 + 16'(exp_idx), exp_idx);
                end
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            @(posedge clk);
            #1;
        end
        checks++; if (rx != 5) begin errors++; $display("FAIL b2b_count: got %0d results expected 5", rx); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra: got out_valid=%b expected 0", bus.out_valid); end
            cyc;
        end
        checks++; if (bus.miss_count !== 16'd2) begin errors++; $display("FAIL b2b_miss_count: got %0d expected 2", bus.miss_count); end
    endtask

    task automatic test_saturation;
        logic ov, h;
        logic [15:0] col;
        logic [5:0] idx;
        bus.frame_start = 1'b1;
        cyc;
        bus.frame_start = 1'b0;
        checks++; if (bus.miss_count !== 16'd0) begin errors++; $display("FAIL fs_clear: got %0d expected 0", bus.miss_count); end
        bus.in_valid   = 1'b1;
        bus.collisions = '0;
        bus.out_ready  = 1'b1;
        repeat (65540) cyc;
        bus.in_valid = 1'b0;
        repeat (3) cyc;
        checks++; if (bus.miss_count !== 16'hFFFF) begin errors++; $display("FAIL sat_value: got %h expected ffff", bus.miss_count); end
        bus.in_valid   = 1'b1;
        bus.collisions = '0;
        cyc;
        bus.in_valid = 1'b0;
        cyc;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fs_miss_valid: got %b expected 1", bus.out_valid); end
        bus.frame_start = 1'b1;
        cyc;
        bus.frame_start = 1'b0;
        checks++; if (bus.miss_count !== 16'd1) begin errors++; $display("FAIL fs_with_miss: got %0d expected 1", bus.miss_count); end
        bus.in_valid   = 1'b1;
        bus.collisions = 64'd1 << 5;
        cyc;
        bus.in_valid = 1'b0;
        cyc;
        bus.frame_start = 1'b1;
        cyc;
        bus.frame_start = 1'b0;
        checks++; if (bus.miss_count !== 16'd0) begin errors++; $display("FAIL fs_with_hit: got %0d expected 0", bus.miss_count); end
        send_one(64'd0, ov, col, h, idx);
        checks++; if (bus.miss_count !== 16'd1) begin errors++; $display("FAIL post_fs_miss: got %0d expected 1", bus.miss_count); end
    endtask

    task automatic test_reset_midflight;
        bus.in_valid   = 1'b1;
        bus.collisions = '0;
        bus.out_ready  = 1'b1;
        cyc;
        cyc;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b expected 1", bus.out_valid); end
        bus.in_valid    = 1'b0;
        rst_n           = 1'b0;
        bus.frame_start = 1'b1;
        cyc;
        rst_n           = 1'b1;
        bus.frame_start = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.miss_count !== 16'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", bus.miss_count); end
        cyc;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: got %b expected 0", bus.out_valid); end
        checks++; if (bus.miss_count !== 16'd0) begin errors++; $display("FAIL mid_no_xfer: got %0d expected 0", bus.miss_count); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_miss;
        test_priority_transparency;
        test_back_to_back;
        test_saturation;
        test_reset_midflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
